// File: rtl/smart_home_pkg.sv
// smart_home_pkg: shared types and constants for the door keypad / password checker path.
//   PW_W            width of password words (5 decimal digits fit in 17 bits)
//   KEY_*           keypad scanner codes for the non-digit keys
//   keypad_state_t  keypad_entry FSM states
package smart_home_pkg;
    localparam int PW_W = 17;
    localparam logic [3:0] KEY_CLEAR  = 4'hA;
    localparam logic [3:0] KEY_BACK   = 4'hB;
    localparam logic [3:0] KEY_CHANGE = 4'hC;
    localparam logic [3:0] KEY_ENTER  = 4'hE;
    typedef enum logic [1:0] {ENTRY, NEW_ENTRY, SETUP, STROBE} keypad_state_t;
endpackage

// File: rtl/keypad_digit_acc.sv
// keypad_digit_acc: decimal digit accumulator with digit count.
//   clk, rst  clock and asynchronous active-high reset
//   push      append digit (ignored when full)
//   back      drop last digit (ignored when empty)
//   clr       clear accumulator and count (highest priority)
//   digit     decimal digit 0..9 for push
//   acc       accumulated value
//   count     digits currently held
//   full      count has reached MAX_DIGITS
module keypad_digit_acc
    import smart_home_pkg::*;
#(
    parameter int MAX_DIGITS = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            back,
    input  logic            clr,
    input  logic [3:0]      digit,
    output logic [PW_W-1:0] acc,
    output logic [2:0]      count,
    output logic            full
);
    logic [PW_W-1:0] acc_mul;
    logic [PW_W-1:0] acc_div;

    assign acc_mul = acc * PW_W'(10) + PW_W'(digit);
    assign acc_div = acc / PW_W'(10);
    assign full    = count >= 3'(MAX_DIGITS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc   <= '0;
            count <= '0;
        end else if (clr) begin
            acc   <= '0;
            count <= '0;
        end else if (push && !full) begin
            acc   <= acc_mul;
            count <= count + 3'd1;
        end else if (back && count != 3'd0) begin
            acc   <= acc_div;
            count <= count - 3'd1;
        end
    end
endmodule

// File: rtl/keypad_entry.sv
// keypad_entry: turns keypad key events into decimal codes and drives the password checker handshake.
//   clk, rst         clock and asynchronous active-high reset
//   key_valid        one-cycle key event; key_code 0-9 digit, A clear, B backspace, C change, E enter
//   in_password      submitted code, held between submits
//   change_password  submitted new code, held between submits
//   rs_buttonState   1 = last submit was a change-password request
//   e_buttonState    enter strobe, high STROBE_CYCLES cycles after a one-cycle setup
//   digit_count      digits in the current accumulator
//   entry_error      one-cycle pulse on a rejected key or an abort
// Optional macro KEYPAD_TIMEOUT_EN adds an inter-key idle abort after TIMEOUT_CYCLES.
module keypad_entry
    import smart_home_pkg::*;
#(
    parameter int MAX_DIGITS    = 5,
    parameter int STROBE_CYCLES = 2
`ifdef KEYPAD_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 1000000
`endif
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            key_valid,
    input  logic [3:0]      key_code,
    output logic [PW_W-1:0] in_password,
    output logic [PW_W-1:0] change_password,
    output logic            rs_buttonState,
    output logic            e_buttonState,
    output logic [2:0]      digit_count,
    output logic            entry_error
);
    keypad_state_t   state;
    logic            chg;
    logic [3:0]      scnt;
    logic [PW_W-1:0] acc;
    logic            full;
    logic            active, is_digit, push, back, clr, enter_ok, chg_ok, strobe_end, timeout, err_c;

    // Keys only count while collecting a code; during the handshake they vanish silently.
    assign active     = key_valid && (state == ENTRY || state == NEW_ENTRY);
    assign is_digit   = key_code <= 4'd9;
    assign push       = active && is_digit && !full;
    assign back       = active && key_code == KEY_BACK && digit_count != 3'd0;
    assign enter_ok   = active && key_code == KEY_ENTER && digit_count != 3'd0;
    assign chg_ok     = active && key_code == KEY_CHANGE && state == ENTRY && digit_count == 3'd0;
    assign strobe_end = state == STROBE && scnt == 4'(STROBE_CYCLES - 1);
    // The accumulator is kept through SETUP/STROBE and emptied as the strobe ends.
    assign clr        = (active && key_code == KEY_CLEAR) || (enter_ok && state == ENTRY && chg) ||
                        strobe_end || timeout;
    assign err_c      = timeout || (active && ((is_digit && full) ||
                        (key_code == KEY_CHANGE && !chg_ok) ||
                        (key_code == KEY_ENTER && digit_count == 3'd0)));

`ifdef KEYPAD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    logic [TW-1:0] tcnt;
    logic          running;
    assign running = (state == ENTRY && (digit_count != 3'd0 || chg)) || state == NEW_ENTRY;
    assign timeout = running && !key_valid && tcnt == TW'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) tcnt <= '0;
        else     tcnt <= (key_valid || !running || timeout) ? '0 : tcnt + TW'(1);
    end
`else
    assign timeout = 1'b0;
`endif

    keypad_digit_acc #(.MAX_DIGITS(MAX_DIGITS)) u_acc (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .back  (back),
        .clr   (clr),
        .digit (key_code),
        .acc   (acc),
        .count (digit_count),
        .full  (full)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= ENTRY;
            chg             <= 1'b0;
            scnt            <= '0;
            in_password     <= '0;
            change_password <= '0;
            rs_buttonState  <= 1'b0;
            e_buttonState   <= 1'b0;
            entry_error     <= 1'b0;
        end else begin
            entry_error <= err_c;
            if (timeout) begin
                state <= ENTRY;
                chg   <= 1'b0;
            end else begin
                case (state)
                    ENTRY: begin
                        if (chg_ok) chg <= 1'b1;
                        if (enter_ok) begin
                            in_password <= acc;
                            if (chg) state <= NEW_ENTRY;
                            else begin
                                rs_buttonState <= 1'b0;
                                state          <= SETUP;
                            end
                        end
                    end
                    NEW_ENTRY: begin
                        if (enter_ok) begin
                            change_password <= acc;
                            rs_buttonState  <= 1'b1;
                            state           <= SETUP;
                        end
                    end
                    SETUP: begin
                        state         <= STROBE;
                        e_buttonState <= 1'b1;
                        scnt          <= '0;
                    end
                    STROBE: begin
                        if (strobe_end) begin
                            state         <= ENTRY;
                            e_buttonState <= 1'b0;
                            chg           <= 1'b0;
                        end else scnt <= scnt + 4'd1;
                    end
                    default: state <= ENTRY;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_keypad_entry.sv
// tb_keypad_entry: scoreboard bench for keypad_entry (submits queued at enter, checked at the strobe).
module tb_keypad_entry;
    import smart_home_pkg::*;

    typedef struct {
        logic [PW_W-1:0] in_pw;
        logic [PW_W-1:0] chg_pw;
        logic            rs;
    } exp_t;

    logic            clk = 0;
    logic            rst = 1;
    logic            key_valid = 0;
    logic [3:0]      key_code = 0;
    logic [PW_W-1:0] in_password, change_password;
    logic            rs_buttonState, e_buttonState, entry_error;
    logic [2:0]      digit_count;

    int vectors = 0;
    int miscompares = 0;
    int strobes = 0;
    logic [PW_W-1:0] m_chg = 0;
    exp_t q[$];

`ifdef KEYPAD_TIMEOUT_EN
    keypad_entry #(.TIMEOUT_CYCLES(16)) dut (
`else
    keypad_entry dut (
`endif
        .clk             (clk),
        .rst             (rst),
        .key_valid       (key_valid),
        .key_code        (key_code),
        .in_password     (in_password),
        .change_password (change_password),
        .rs_buttonState  (rs_buttonState),
        .e_buttonState   (e_buttonState),
        .digit_count     (digit_count),
        .entry_error     (entry_error)
    );

    always #5 clk = ~clk;
    always @(posedge e_buttonState) strobes++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Called at a negedge; returns the entry_error seen after the key was sampled.
    task automatic press(input logic [3:0] k, output logic err);
        key_code  = k;
        key_valid = 1;
        @(negedge clk);
        key_valid = 0;
        err = entry_error;
    endtask

    // Called at the negedge right after an accepted enter (SETUP). Optionally injects
    // key k during the first strobe cycle, which must be dropped silently.
    task automatic check_submit(input string name, input bit inject, input logic [3:0] k);
        exp_t x;
        int   hi = 0;
        bit   err_seen = 0;
        vectors++;
        if (q.size() == 0) begin
            miscompares++;
            $display("FAIL %s: scoreboard empty", name);
            return;
        end
        x = q.pop_front();
        if (e_buttonState !== 0 || in_password !== x.in_pw || change_password !== x.chg_pw ||
            rs_buttonState !== x.rs) begin
            miscompares++;
            $display("FAIL %s setup: e=%b in=%0d chg=%0d rs=%b, expected e=0 in=%0d chg=%0d rs=%b",
                     name, e_buttonState, in_password, change_password, rs_buttonState,
                     x.in_pw, x.chg_pw, x.rs);
        end
        for (int i = 0; i < 20; i++) begin
            key_code  = k;
            key_valid = inject && i == 1;
            @(negedge clk);
            key_valid = 0;
            if (entry_error) err_seen = 1;
            if (e_buttonState) begin
                hi++;
                vectors++;
                if (in_password !== x.in_pw || change_password !== x.chg_pw || rs_buttonState !== x.rs) begin
                    miscompares++;
                    $display("FAIL %s strobe: in=%0d chg=%0d rs=%b, expected in=%0d chg=%0d rs=%b",
                             name, in_password, change_password, rs_buttonState,
                             x.in_pw, x.chg_pw, x.rs);
                end
            end else if (hi > 0) break;
        end
        vectors++;
        if (hi !== 2 || digit_count !== 0 || err_seen) begin
            miscompares++;
            $display("FAIL %s end: strobe_len=%0d count=%0d err=%b, expected 2 0 0",
                     name, hi, digit_count, err_seen);
        end
    endtask

    task automatic test_reset;
        vectors++;
        if (in_password !== 0 || change_password !== 0 || rs_buttonState !== 0 ||
            e_buttonState !== 0 || digit_count !== 0 || entry_error !== 0) begin
            miscompares++;
            $display("FAIL reset: in=%0d chg=%0d rs=%b e=%b cnt=%0d err=%b, expected all 0",
                     in_password, change_password, rs_buttonState, e_buttonState,
                     digit_count, entry_error);
        end
    endtask

    task automatic test_basic;
        logic [3:0] ks[5] = '{4'd4, 4'd5, 4'd6, 4'd7, 4'd5};
        logic er;
        int   s0 = strobes;
        for (int i = 0; i < 5; i++) begin
            press(ks[i], er);
            vectors++;
            if (er !== 0 || digit_count !== 3'(i + 1)) begin
                miscompares++;
                $display("FAIL basic digit %0d: err=%b cnt=%0d, expected 0 %0d", i, er, digit_count, i + 1);
            end
        end
        press(KEY_ENTER, er);
        q.push_back('{17'd45675, m_chg, 1'b0});
        check_submit("basic", 0, 4'd0);
        vectors++;
        if (strobes !== s0 + 1) begin
            miscompares++;
            $display("FAIL basic strobes: %0d, expected %0d", strobes - s0, 1);
        end
    endtask

    task automatic test_change;
        logic er;
        int   s0 = strobes;
        press(KEY_CHANGE, er);
        press(4'd1, er);
        press(4'd2, er);
        press(4'd3, er);
        press(KEY_ENTER, er);
        vectors++;
        if (er !== 0 || e_buttonState !== 0 || digit_count !== 0 || in_password !== 17'd123) begin
            miscompares++;
            $display("FAIL change first enter: err=%b e=%b cnt=%0d in=%0d, expected 0 0 0 123",
                     er, e_buttonState, digit_count, in_password);
        end
        press(4'd9, er);
        press(4'd9, er);
        vectors++;
        if (strobes !== s0 || e_buttonState !== 0) begin
            miscompares++;
            $display("FAIL change early strobe: strobes=%0d e=%b, expected 0 0", strobes - s0, e_buttonState);
        end
        press(KEY_ENTER, er);
        m_chg = 17'd99;
        q.push_back('{17'd123, m_chg, 1'b1});
        check_submit("change", 0, 4'd0);
        vectors++;
        if (strobes !== s0 + 1) begin
            miscompares++;
            $display("FAIL change strobes: %0d, expected 1", strobes - s0);
        end
    endtask

    task automatic test_overflow;
        logic er;
        for (int i = 1; i <= 5; i++) press(4'(i), er);
        press(4'd6, er);
        vectors++;
        if (er !== 1 || digit_count !== 5) begin
            miscompares++;
            $display("FAIL overflow: err=%b cnt=%0d, expected 1 5", er, digit_count);
        end
        press(KEY_ENTER, er);
        q.push_back('{17'd12345, m_chg, 1'b0});
        check_submit("overflow", 0, 4'd0);
        press(4'd1, er);
        press(4'd2, er);
        press(4'd3, er);
        press(KEY_BACK, er);
        vectors++;
        if (er !== 0 || digit_count !== 2) begin
            miscompares++;
            $display("FAIL backspace: err=%b cnt=%0d, expected 0 2", er, digit_count);
        end
        press(KEY_ENTER, er);
        q.push_back('{17'd12, m_chg, 1'b0});
        check_submit("backspace", 0, 4'd0);
        press(4'd4, er);
        press(KEY_CLEAR, er);
        vectors++;
        if (er !== 0 || digit_count !== 0) begin
            miscompares++;
            $display("FAIL clear: err=%b cnt=%0d, expected 0 0", er, digit_count);
        end
    endtask

    task automatic test_errors;
        logic er;
        int   s0 = strobes;
        press(KEY_ENTER, er);
        repeat (3) @(negedge clk);
        vectors++;
        if (er !== 1 || strobes !== s0 || in_password !== 17'd12) begin
            miscompares++;
            $display("FAIL empty enter: err=%b strobes=%0d in=%0d, expected 1 0 12", er, strobes - s0, in_password);
        end
        press(KEY_BACK, er);
        vectors++;
        if (er !== 0 || digit_count !== 0) begin
            miscompares++;
            $display("FAIL empty backspace: err=%b cnt=%0d, expected 0 0", er, digit_count);
        end
        press(4'd1, er);
        press(KEY_CHANGE, er);
        vectors++;
        if (er !== 1) begin
            miscompares++;
            $display("FAIL late change: err=%b, expected 1", er);
        end
        press(KEY_CLEAR, er);
        press(4'd0, er);
        press(KEY_ENTER, er);
        q.push_back('{17'd0, m_chg, 1'b0});
        check_submit("zero code + key in strobe", 1, 4'd5);
    endtask

    task automatic test_async_reset;
        logic er;
        press(4'd9, er);
        press(KEY_ENTER, er);
        @(negedge clk);
        vectors++;
        if (e_buttonState !== 1 || in_password !== 17'd9) begin
            miscompares++;
            $display("FAIL pre-reset strobe: e=%b in=%0d, expected 1 9", e_buttonState, in_password);
        end
        #1 rst = 1;
        #1;
        vectors++;
        if (e_buttonState !== 0 || rs_buttonState !== 0 || in_password !== 0 || change_password !== 0) begin
            miscompares++;
            $display("FAIL async reset: e=%b rs=%b in=%0d chg=%0d, expected all 0",
                     e_buttonState, rs_buttonState, in_password, change_password);
        end
        @(negedge clk);
        rst = 0;
        m_chg = 0;
        @(negedge clk);
        press(4'd7, er);
        press(KEY_ENTER, er);
        q.push_back('{17'd7, m_chg, 1'b0});
        check_submit("after reset", 0, 4'd0);
    endtask

`ifdef KEYPAD_TIMEOUT_EN
    task automatic test_timeout;
        logic er;
        int   at = -1;
        int   s0 = strobes;
        press(4'd3, er);
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (entry_error) begin
                at = i;
                break;
            end
        end
        vectors++;
        if (at !== 16 || digit_count !== 0 || strobes !== s0 || in_password !== 17'd7) begin
            miscompares++;
            $display("FAIL timeout: err_at=%0d cnt=%0d strobes=%0d in=%0d, expected 16 0 0 7",
                     at, digit_count, strobes - s0, in_password);
        end
    endtask
`endif

    initial begin
        repeat (2) @(negedge clk);
        test_reset;
        rst = 0;
        @(negedge clk);
        test_basic;
        test_change;
        test_overflow;
        test_errors;
        test_async_reset;
`ifdef KEYPAD_TIMEOUT_EN
        test_timeout;
`endif
        vectors++;
        if (q.size() !== 0) begin
            miscompares++;
            $display("FAIL scoreboard leftover: %0d entries, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/keypad_entry.md
Name: keypad_entry

Overview:
Front-end for the door password checker. It turns single-cycle key events from the keypad scanner into a decimal code, with optional change-password sequencing. It drives the checker's in_password, change_password, rs_buttonState and e_buttonState inputs. There is one instance per door, between the keypad scanner and the password checker.

Parameters:
PW_W, 17, width of password words (max 5 decimal digits, 99999 < 2^17)
MAX_DIGITS, 5, digits accepted per code
STROBE_CYCLES, 2, cycles e_buttonState is held high (range 1..15)
TIMEOUT_CYCLES, 1000000, inter-key idle limit (used only with the optional feature)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset; asynchronous, active-high
key_valid  input  1  one-cycle key event from the scanner
key_code  input  4  key code: 0x0-0x9 digit, 0xA clear, 0xB backspace, 0xC change, 0xE enter; 0xD and 0xF ignored
in_password  output  PW_W  submitted code; holds between submits
change_password  output  PW_W  submitted new code; holds between submits
rs_buttonState  output  1  1 = the submit is a change-password request
e_buttonState  output  1  enter strobe to the checker
digit_count  output  3  digits in the current accumulator
entry_error  output  1  one-cycle pulse on a rejected key or an abort

Behaviour:
- Reset: async clear. All outputs 0; state ENTRY; accumulator 0; change flag 0; strobe counter 0. Reset during SETUP or STROBE drops e_buttonState immediately.
- States and transitions:
  - ENTRY: collecting the first code.
  - NEW_ENTRY: collecting the new code (change flow only).
  - SETUP: 1 cycle, outputs stable, e low.
  - STROBE: e high for exactly STROBE_CYCLES cycles.
  - After STROBE: go to ENTRY; clear accumulator, digit_count and change flag. in_password and change_password are not cleared.
- Key events are acted on only in ENTRY or NEW_ENTRY. In SETUP or STROBE they are dropped silently, with no error.
- Digit d:
  - If count < MAX_DIGITS: acc <= acc*10 + d, count++. Register the result one cycle after key_valid.
  - If count = MAX_DIGITS: key dropped, entry_error pulse.
- 0xA clear: acc = 0, count = 0, state unchanged, change flag kept.
- 0xB backspace: if count > 0, acc <= acc/10 and count--. If count = 0, no-op, no error.
- 0xC change:
  - Accepted only in ENTRY with count = 0: set change flag.
  - Elsewhere: dropped, entry_error pulse.
- 0xE enter:
  - count = 0: entry_error pulse; nothing latched.
  - ENTRY, flag 0: in_password <= acc, rs_buttonState <= 0, go to SETUP.
  - ENTRY, flag 1: in_password <= acc, clear acc and count, go to NEW_ENTRY.
  - NEW_ENTRY: change_password <= acc, rs_buttonState <= 1, go to SETUP.
- Handshake timing: rs_buttonState, in_password and change_password are stable from SETUP through the last STROBE cycle. This gives the checker a clean rising edge with data already settled.
- rs_buttonState holds its last value until the next submit.
- Zero-valued codes (for example, keys 0 then E) are legal submits.

Optional Feature:
Macro KEYPAD_TIMEOUT_EN.
- With it: a counter resets on every accepted or dropped key event. It runs in ENTRY when count > 0 or the flag is set, and always in NEW_ENTRY. When it reaches TIMEOUT_CYCLES-1:
  - abort: clear acc, count and flag; go to ENTRY; entry_error pulse;
  - in_password and change_password are unchanged.
- Without it: no counter exists, and entry waits indefinitely.

Decomposition:
- Shared package smart_home_pkg:
  - PW_W;
  - key-code constants KEY_CLEAR, KEY_BACK, KEY_CHANGE, KEY_ENTER;
  - enum keypad_state_t {ENTRY, NEW_ENTRY, SETUP, STROBE}.
- One sub-module, keypad_digit_acc: accumulator plus count.
  - Inputs: push digit, backspace, clear.
  - Outputs: acc, count, full.
  - Multiply and divide by 10 are combinational inside it.
- The FSM, strobe counter and timeout live in keypad_entry.

Test Plan:
- Keys 4,5,6,7,5,E -> in_password=45675, rs=0; one SETUP cycle, then e high 2 cycles, then digit_count=0.
- Keys C,1,2,3,E,9,9,E -> in_password=123, change_password=99, rs=1 during SETUP and STROBE; e strobes once, only after the second E.
- Keys 1,2,3,4,5,6,E -> entry_error pulse on 6; submit 12345. Then keys 1,2,3,B,E -> submit 12.
- Key E with count 0, then key 5 during STROBE -> entry_error on the E with no strobe; the 5 is ignored with no error and digit_count stays 0.
- Assert rst in the first STROBE cycle -> e, rs, in_password and change_password all 0 asynchronously; after release, keys 7,E submit 7 normally.
- (KEYPAD_TIMEOUT_EN, TIMEOUT_CYCLES=16) Key 3, then idle 16 cycles -> entry_error pulse, digit_count=0, no strobe, in_password unchanged.
